// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Sequential signed multiplier/divider feeding the HI/LO registers.
//   Multiply: radix-2 Booth, one bit per cycle, WIDTH iterations.
//   Divide:   restoring shift-subtract on operand magnitudes, followed by a
//             one-cycle sign fix-up (remainder takes the dividend's sign).
//
// Ports
//   clock     rising-edge system clock
//   reset     asynchronous, active-high reset
//   mult_div  command: 00 none, 01 start mult, 10 start div, 11 ignored
//   a, b      operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo    result registers (product upper/lower, or remainder/quotient)
//   busy      high while an operation is in flight
//   done      one-cycle pulse when hi/lo have been updated (or div0 flagged)
//   div0      one-cycle pulse: divide by zero, hi/lo left unchanged
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mult_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Which result FINISH should commit.
    localparam logic [1:0] KIND_MULT = 2'd0;
    localparam logic [1:0] KIND_DIV  = 2'd1;
    localparam logic [1:0] KIND_DIV0 = 2'd2;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, FINISH} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       kind_reg;

    // Booth product register {acc, q, qm1}; acc is one bit wider than the
    // operands so subtracting M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qm1_reg;
    logic [WIDTH:0]   m_reg;

    // Restoring divider: partial remainder, dividend/quotient shifter, |b|.
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;

    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             done_reg, div0_reg;

    logic             start_mult, start_div, b_zero, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] r_shift, r_sub;
    logic             r_ge;

    assign start_mult = (mult_div == 2'b01);
    assign start_div  = (mult_div == 2'b10);
    assign b_zero     = (b == '0);
    assign last_iter  = (cnt_reg == CW'(WIDTH - 1));

    // |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit magnitude.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Booth add/subtract selected by the bit pair {Q0, Q-1}.
    always_comb begin
        booth_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_reg;
            2'b10:   booth_sum = acc_reg - m_reg;
            default: booth_sum = acc_reg;
        endcase
    end

    // The partial remainder is always below |b| <= 2^(WIDTH-1), so its MSB is
    // zero and dropping it on the shift loses nothing.
    assign r_shift = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
    assign r_ge    = (r_shift >= dvs_reg);
    assign r_sub   = r_shift - dvs_reg;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_mult) begin
                    state_next = MULT;
                end else if (start_div) begin
                    state_next = b_zero ? FINISH : DIV;
                end
            end
            MULT:    if (last_iter) state_next = FINISH;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            kind_reg   <= KIND_MULT;
            acc_reg    <= '0;
            q_reg      <= '0;
            qm1_reg    <= 1'b0;
            m_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (start_mult) begin
                        kind_reg <= KIND_MULT;
                        m_reg    <= {a[WIDTH-1], a};
                        acc_reg  <= '0;
                        q_reg    <= b;
                        qm1_reg  <= 1'b0;
                    end else if (start_div) begin
                        if (b_zero) begin
                            kind_reg <= KIND_DIV0;
                        end else begin
                            kind_reg   <= KIND_DIV;
                            rem_reg    <= '0;
                            quo_reg    <= a_mag;
                            dvs_reg    <= b_mag;
                            sign_a_reg <= a[WIDTH-1];
                            sign_b_reg <= b[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    // Arithmetic right shift of the whole {acc, q, qm1}.
                    acc_reg <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_reg   <= {booth_sum[0], q_reg[WIDTH-1:1]};
                    qm1_reg <= q_reg[0];
                    cnt_reg <= cnt_reg + CW'(1);
                end
                DIV: begin
                    rem_reg <= r_ge ? r_sub : r_shift;
                    quo_reg <= {quo_reg[WIDTH-2:0], r_ge};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                FIX: begin
                    if (sign_a_reg != sign_b_reg) quo_reg <= -quo_reg;
                    if (sign_a_reg)               rem_reg <= -rem_reg;
                end
                FINISH: begin
                    done_reg <= 1'b1;
                    case (kind_reg)
                        KIND_MULT: begin
                            hi_reg <= acc_reg[WIDTH-1:0];
                            lo_reg <= q_reg;
                        end
                        KIND_DIV: begin
                            hi_reg <= rem_reg;
                            lo_reg <= quo_reg;
                        end
                        default: div0_reg <= 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign done = done_reg;
    assign div0 = div0_reg;
    assign busy = (state_reg != IDLE);

endmodule
